// File: rtl/sprite_pixel_renderer.sv
// Two-sprite XGA pixel renderer: prefetches each sprite row in h-blank and draws registered RGB + syncs, 2-clock latency.
// Optional sticky sprite-overlap flag compiled in with SPRITE_COLLISION_EN.
module sprite_pixel_renderer #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int V_TOTAL     = 806,
  parameter int SCALE_SHIFT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [10:0]  h_cnt,
  input  logic [9:0]   v_cnt,
  input  logic         visible_in,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic [7:0]   spr0_x,
  input  logic [7:0]   spr0_y,
  input  logic [7:0]   spr1_x,
  input  logic [7:0]   spr1_y,
  input  logic [2:0]   spr0_ctrl,
  input  logic [2:0]   spr1_ctrl,
  input  logic [143:0] spr0_bmp,
  input  logic [143:0] spr1_bmp,
  output logic [5:0]   rgb_out,
  output logic [7:0]   uo_out,
  output logic         collision,
  input  logic         collision_clr
);

  logic [7:0]   spr_x_a [2];
  logic [7:0]   spr_y_a [2];
  logic [2:0]   ctrl_a  [2];
  logic [143:0] bmp_a   [2];

  assign spr_x_a[0] = spr0_x;
  assign spr_x_a[1] = spr1_x;
  assign spr_y_a[0] = spr0_y;
  assign spr_y_a[1] = spr1_y;
  assign ctrl_a[0]  = spr0_ctrl;
  assign ctrl_a[1]  = spr1_ctrl;
  assign bmp_a[0]   = spr0_bmp;
  assign bmp_a[1]   = spr1_bmp;

  logic [31:0] unused_v_active;
  assign unused_v_active = V_ACTIVE;

  logic [9:0] next_v;
  logic [7:0] nly;
  logic       prefetch;

  assign next_v   = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
  assign nly      = 8'(next_v >> SCALE_SHIFT);
  assign prefetch = enable && (h_cnt == 11'(H_ACTIVE));

  logic [7:0] lx1;
  logic       vis1, hs1, vs1;
  logic [1:0] hit;
  logic [1:0] pal_a [2];

  generate
    for (genvar s = 0; s < 2; s++) begin : g_spr
      logic [8:0]  d, c;
      logic [7:0]  base;
      logic [11:0] raw, raw_rev;
      logic [11:0] row_bits;
      logic [7:0]  row_x;
      logic [1:0]  row_pal;
      logic        row_valid;

      // 9-bit difference: a borrow lands in bit 8 and fails the < 12 test.
      assign d       = {1'b0, nly} - {1'b0, spr_y_a[s]};
      assign base    = 8'(d[3:0]) * 8'd12;
      assign raw     = bmp_a[s][base +: 12];
      assign raw_rev = {<<{raw}};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_valid <= 1'b0;
          row_bits  <= '0;
          row_x     <= '0;
          row_pal   <= '0;
        end else if (!enable) begin
          row_valid <= 1'b0;
        end else if (prefetch) begin
          row_valid <= (d < 9'd12);
          if (d < 9'd12) begin
            row_bits <= ctrl_a[s][2] ? raw_rev : raw;
            row_x    <= spr_x_a[s];
            row_pal  <= ctrl_a[s][1:0];
          end
        end
      end

      assign c        = {1'b0, lx1} - {1'b0, row_x};
      assign hit[s]   = row_valid && (c < 9'd12) && row_bits[c[3:0]];
      assign pal_a[s] = row_pal;
    end
  endgenerate

  function automatic logic [5:0] pal_rgb(input logic [1:0] p);
    case (p)
      2'd0:    pal_rgb = 6'b00_00_11;
      2'd1:    pal_rgb = 6'b00_11_00;
      2'd2:    pal_rgb = 6'b11_00_00;
      default: pal_rgb = 6'b11_11_11;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx1  <= '0;
      vis1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
    end else begin
      lx1  <= 8'(h_cnt >> SCALE_SHIFT);
      vis1 <= visible_in & enable;
      hs1  <= hsync_in & enable;
      vs1  <= vsync_in & enable;
    end
  end

  logic [5:0] rgb_d;
  logic       hs2, vs2;

  always_comb begin
    rgb_d = 6'd0;
    if (vis1) begin
      if (hit[1])      rgb_d = pal_rgb(pal_a[1]);
      else if (hit[0]) rgb_d = pal_rgb(pal_a[0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out <= '0;
      hs2     <= 1'b0;
      vs2     <= 1'b0;
    end else begin
      rgb_out <= rgb_d;
      hs2     <= hs1;
      vs2     <= vs1;
    end
  end

  // TinyVGA PMOD pin order.
  assign uo_out = {hs2, rgb_out[0], rgb_out[2], rgb_out[4],
                   vs2, rgb_out[1], rgb_out[3], rgb_out[5]};

`ifdef SPRITE_COLLISION_EN
  logic coll_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                coll_q <= 1'b0;
    else if (vis1 && (&hit))   coll_q <= 1'b1;
    else if (collision_clr)    coll_q <= 1'b0;
  end
  assign collision = coll_q;
`else
  logic unused_clr;
  assign unused_clr = collision_clr;
  assign collision  = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pixel_renderer.sv
// Scoreboard bench for sprite_pixel_renderer: driver queues hand-derived pixel expectations, monitor checks them 2 clocks later.
module tb_sprite_pixel_renderer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [10:0]  h_cnt;
  logic [9:0]   v_cnt;
  logic         visible_in, hsync_in, vsync_in;
  logic [7:0]   spr0_x, spr0_y, spr1_x, spr1_y;
  logic [2:0]   spr0_ctrl, spr1_ctrl;
  logic [143:0] spr0_bmp, spr1_bmp;
  logic [5:0]   rgb_out;
  logic [7:0]   uo_out;
  logic         collision;
  logic         collision_clr;

  sprite_pixel_renderer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .visible_in(visible_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .spr0_x(spr0_x), .spr0_y(spr0_y), .spr1_x(spr1_x), .spr1_y(spr1_y),
    .spr0_ctrl(spr0_ctrl), .spr1_ctrl(spr1_ctrl),
    .spr0_bmp(spr0_bmp), .spr1_bmp(spr1_bmp),
    .rgb_out(rgb_out), .uo_out(uo_out), .collision(collision),
    .collision_clr(collision_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [5:0] rgb;
    logic [7:0] uo;
    logic       coll;
    bit         chk;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic coll_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] pack(input logic [5:0] rgb, input logic hs, input logic vs);
    return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
  endfunction

  // Monitor: outputs are sampled 1 time unit after the edge they were due on.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.due < cyc) check("stale_entry", 8'(cyc - e.due), 8'd0);
        else if (e.chk) begin
          check("rgb", {2'b0, rgb_out}, {2'b0, e.rgb});
          check("uo", uo_out, e.uo);
          check("coll", {7'b0, collision}, {7'b0, e.coll});
        end
      end
    end
  end

  // One cycle at h == H_ACTIVE on line vp: loads the rows for line vp+1.
  task automatic prep(input int vp);
    exp_t e;
    @(negedge clk);
    h_cnt = 11'd1024; v_cnt = 10'(vp); enable = 1'b1;
    visible_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; collision_clr = 1'b0;
    e.due = cyc + 2; e.rgb = '0; e.uo = '0; e.coll = 1'b0; e.chk = 1'b0;
    q.push_back(e);
  endtask

  // Drive line v; sprite 0 covers h lo0..hi0 in colour c0, sprite 1 covers lo1..hi1 in c1 (on top).
  task automatic line(input int v, input int h_end, input bit en,
                      input int lo0, input int hi0, input logic [5:0] c0,
                      input int lo1, input int hi1, input logic [5:0] c1,
                      input int wr_h, input int clr_h);
    for (int h = 0; h <= h_end; h++) begin
      exp_t e;
      bit vis, in0, in1, hs, vs;
      @(negedge clk);
      if (h == wr_h) spr0_x = 8'd50;
      collision_clr = (h == clr_h);
      hs = (h >= 1048 && h < 1184);
      vs = (v >= 771 && v < 777);
      h_cnt = 11'(h); v_cnt = 10'(v); enable = en;
      visible_in = (h < 1024 && v < 768);
      hsync_in = hs; vsync_in = vs;
      vis = visible_in && en;
      in0 = (h >= lo0 && h <= hi0);
      in1 = (h >= lo1 && h <= hi1);
      e.rgb = !vis ? 6'h00 : in1 ? c1 : in0 ? c0 : 6'h00;
      e.uo  = pack(e.rgb, hs && en, vs && en);
`ifdef SPRITE_COLLISION_EN
      // The clear lands on the edge where the previous pixel's output appears.
      if (h == clr_h) begin
        coll_exp = 1'b0;
        if (q.size() > 0) q[$].coll = 1'b0;
      end
      if (vis && in0 && in1) coll_exp = 1'b1;
`endif
      e.coll = coll_exp;
      e.due = cyc + 2;
      e.chk = 1'b1;
      q.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; h_cnt = '0; v_cnt = '0;
    visible_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; collision_clr = 1'b0;
    spr0_x = 8'd10; spr0_y = 8'd5; spr0_ctrl = 3'b011; spr0_bmp = '1;
    spr1_x = 8'd14; spr1_y = 8'd200; spr1_ctrl = 3'b010; spr1_bmp = '1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_rgb", {2'b0, rgb_out}, 8'h00);
    check("reset_uo", uo_out, 8'h00);
    check("reset_coll", {7'b0, collision}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Full white sprite at x=10,y=5 on line 20: lx 10..21.
    prep(19);
    line(20, 1343, 1'b1, 40, 87, 6'h3F, -1, -2, 6'h00, -1, -1);

    // Single pixel at row 0 col 0, unflipped then flipped.
    spr0_bmp = 144'd1;
    prep(19);
    line(20, 1343, 1'b1, 40, 43, 6'h3F, -1, -2, 6'h00, -1, -1);
    spr0_ctrl = 3'b111;
    prep(19);
    line(20, 1343, 1'b1, 84, 87, 6'h3F, -1, -2, 6'h00, -1, -1);

    // Green sprite 0 at x=10 under red sprite 1 at x=14; clear collision mid-line.
    spr0_bmp = '1; spr0_ctrl = 3'b001; spr1_y = 8'd5;
    prep(19);
    line(20, 1343, 1'b1, 40, 87, 6'h0C, 56, 103, 6'h30, -1, 300);
    line(21, 1343, 1'b1, 40, 87, 6'h0C, 56, 103, 6'h30, -1, -1);
    spr1_y = 8'd200;

    // Mid-line x change takes effect only on the following line.
    spr0_ctrl = 3'b011;
    prep(19);
    line(20, 1343, 1'b1, 40, 87, 6'h3F, -1, -2, 6'h00, 500, -1);
    line(21, 1343, 1'b1, 200, 247, 6'h3F, -1, -2, 6'h00, -1, -1);

    // Line 0 is fetched on the last line of the frame.
    spr0_x = 8'd10; spr0_y = 8'd0;
    prep(805);
    line(0, 1343, 1'b1, 40, 87, 6'h3F, -1, -2, 6'h00, -1, -1);

    // Right-edge clip: lx 250..255 only, nothing wraps to lx 0.
    spr0_x = 8'd250; spr0_y = 8'd5;
    prep(19);
    line(20, 1343, 1'b1, 1000, 1047, 6'h3F, -1, -2, 6'h00, -1, -1);

    // Disable blanks everything and drops the rows; first line back is black.
    spr0_x = 8'd10;
    prep(19);
    line(20, 1343, 1'b0, 40, 87, 6'h3F, -1, -2, 6'h00, -1, -1);
    line(21, 1343, 1'b1, -1, -2, 6'h00, -1, -2, 6'h00, -1, -1);
    line(22, 1343, 1'b1, 40, 87, 6'h3F, -1, -2, 6'h00, -1, -1);

    // Asynchronous reset in the middle of a lit span.
    prep(19);
    line(20, 59, 1'b1, 40, 87, 6'h3F, -1, -2, 6'h00, -1, -1);
    @(posedge clk);
    #2;
    check("pre_reset_rgb", {2'b0, rgb_out}, 8'h3F);
    q.delete();
    rst_n = 1'b0;
    #1;
    check("async_reset_rgb", {2'b0, rgb_out}, 8'h00);
    check("async_reset_uo", uo_out, 8'h00);
    check("async_reset_coll", {7'b0, collision}, 8'h00);
    coll_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    line(21, 1343, 1'b1, -1, -2, 6'h00, -1, -2, 6'h00, -1, -1);

    repeat (4) @(negedge clk);
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
